// File: rtl/triangle_dispatcher_pkg.sv
// Shared types and constants for the triangle dispatcher slice.
package triangle_dispatcher_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned Z_W     = 6;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned COMP_W  = 32;

  localparam logic [Z_W-1:0]     Z_FAR    = 6'h3F;
  localparam logic [COLOR_W-1:0] BG_COLOR = 4'h0;

  // One raster-space vertex: {x, y, z} as fp32 bit patterns.
  typedef logic [2:0][COMP_W-1:0] vertex_t;

  typedef struct packed {
    vertex_t              p1;
    vertex_t              p2;
    vertex_t              p3;
    logic [COLOR_W-1:0]   color;
  } triangle_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_DISPATCH  = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } disp_state_e;

endpackage

// File: rtl/triangle_dispatcher_if.sv
// Upstream triangle channel, rasterizer handshake and memory ports of the dispatcher.
interface triangle_dispatcher_if;
  import triangle_dispatcher_pkg::*;

  logic               tri_valid;
  logic               tri_ready;
  vertex_t            tri_p1;
  vertex_t            tri_p2;
  vertex_t            tri_p3;
  logic [COLOR_W-1:0] tri_color;

  logic               frame_start;
  logic               frame_end;
  logic               frame_busy;
  logic               frame_done;

  logic               rast_start;
  vertex_t            rast_p1;
  vertex_t            rast_p2;
  vertex_t            rast_p3;
  logic [COLOR_W-1:0] rast_color;
  logic               rast_done;

  logic               rast_fb_we;
  logic [COORD_W-1:0] rast_fb_x;
  logic [COORD_W-1:0] rast_fb_y;
  logic [COLOR_W-1:0] rast_fb_data;
  logic               rast_zb_we;
  logic [COORD_W-1:0] rast_zb_x;
  logic [COORD_W-1:0] rast_zb_y;
  logic [Z_W-1:0]     rast_zb_wdata;
  logic [Z_W-1:0]     rast_zb_rdata;

  logic               fb_we;
  logic [COORD_W-1:0] fb_x;
  logic [COORD_W-1:0] fb_y;
  logic [COLOR_W-1:0] fb_data;
  logic               zb_we;
  logic [COORD_W-1:0] zb_x;
  logic [COORD_W-1:0] zb_y;
  logic [Z_W-1:0]     zb_wdata;
  logic [Z_W-1:0]     zb_rdata;

  // Environment side: upstream feeder, rasterizer and memories.
  modport master (
    output tri_valid, tri_p1, tri_p2, tri_p3, tri_color,
    output frame_start, frame_end, rast_done,
    output rast_fb_we, rast_fb_x, rast_fb_y, rast_fb_data,
    output rast_zb_we, rast_zb_x, rast_zb_y, rast_zb_wdata, zb_rdata,
    input  tri_ready, frame_busy, frame_done,
    input  rast_start, rast_p1, rast_p2, rast_p3, rast_color, rast_zb_rdata,
    input  fb_we, fb_x, fb_y, fb_data, zb_we, zb_x, zb_y, zb_wdata
  );

  // Dispatcher side.
  modport slave (
    input  tri_valid, tri_p1, tri_p2, tri_p3, tri_color,
    input  frame_start, frame_end, rast_done,
    input  rast_fb_we, rast_fb_x, rast_fb_y, rast_fb_data,
    input  rast_zb_we, rast_zb_x, rast_zb_y, rast_zb_wdata, zb_rdata,
    output tri_ready, frame_busy, frame_done,
    output rast_start, rast_p1, rast_p2, rast_p3, rast_color, rast_zb_rdata,
    output fb_we, fb_x, fb_y, fb_data, zb_we, zb_x, zb_y, zb_wdata
  );

endinterface

// File: rtl/triangle_dispatcher_tri_fifo.sv
// Synchronous FIFO of triangles; pushes when full and pops when empty are ignored.
module tri_fifo
  import triangle_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   push,
  input  triangle_t              push_data,
  input  logic                   pop,
  output triangle_t              pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  triangle_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/triangle_dispatcher.sv
// Triangle FIFO, frame clear engine and rasterizer launcher; owns the fb/zb write ports.
module triangle_dispatcher
  import triangle_dispatcher_pkg::*;
#(
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter int unsigned        H_RES      = 640,
  parameter int unsigned        V_RES      = 480,
  parameter logic [Z_W-1:0]     Z_FAR_VAL  = triangle_dispatcher_pkg::Z_FAR,
  parameter logic [COLOR_W-1:0] BG_VAL     = triangle_dispatcher_pkg::BG_COLOR
) (
  input logic                  clk,
  input logic                  areset,
  triangle_dispatcher_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (H_RES == 0 || V_RES == 0 || H_RES > 1024 || V_RES > 1024) begin : g_bad_res
    $error("triangle_dispatcher: H_RES/V_RES must be in 1..1024");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("triangle_dispatcher: FIFO_DEPTH must be a power of two >= 2");
  end

  disp_state_e        state_q, state_d;
  logic [COORD_W-1:0] clr_x_q, clr_x_d;
  logic [COORD_W-1:0] clr_y_q, clr_y_d;
  logic               end_pending_q, end_pending_d;
  logic               clr_last;
  logic               pop;
  logic               frame_busy_q, frame_done_q, rast_start_q;
  triangle_t          rast_tri_q;
  triangle_t          push_data, head;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  assign push_data = '{p1: bus.tri_p1, p2: bus.tri_p2, p3: bus.tri_p3, color: bus.tri_color};
  assign bus.tri_ready = ~fifo_full;

  tri_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .areset    (areset),
    .push      (bus.tri_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign clr_last = (state_q == ST_CLEAR) &&
                    (clr_x_q == COORD_W'(H_RES - 1)) &&
                    (clr_y_q == COORD_W'(V_RES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: clear sweep, then one triangle at a time on the start/done handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.frame_start) state_d = ST_CLEAR;
      ST_CLEAR:     if (clr_last) state_d = ST_DISPATCH;
      ST_DISPATCH: begin
        if (bus.rast_done) begin
          if (!fifo_empty)        state_d = ST_LAUNCH;
          else if (end_pending_q) state_d = ST_IDLE;
        end
      end
      ST_LAUNCH:    state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (!bus.rast_done) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.rast_done) state_d = ST_DISPATCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs of the FSM: FIFO pop, clear-sweep counters and end-of-frame latch.
  always_comb begin
    pop           = 1'b0;
    clr_x_d       = clr_x_q;
    clr_y_d       = clr_y_q;
    end_pending_d = end_pending_q;
    if (state_q == ST_IDLE) begin
      if (bus.frame_start) begin
        clr_x_d       = '0;
        clr_y_d       = '0;
        end_pending_d = 1'b0;
      end
    end else if (bus.frame_end) begin
      end_pending_d = 1'b1;
    end
    if (state_q == ST_CLEAR) begin
      if (clr_x_q == COORD_W'(H_RES - 1)) begin
        clr_x_d = '0;
        clr_y_d = clr_y_q + COORD_W'(1);
      end else begin
        clr_x_d = clr_x_q + COORD_W'(1);
      end
    end
    if (state_q == ST_DISPATCH && bus.rast_done && fifo_count != '0) pop = 1'b1;
  end

  // Registered status/handshake outputs and the held triangle for the rasterizer.
  always_ff @(posedge clk) begin
    if (areset) begin
      clr_x_q       <= '0;
      clr_y_q       <= '0;
      end_pending_q <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      rast_start_q  <= 1'b0;
      rast_tri_q    <= '0;
    end else begin
      clr_x_q       <= clr_x_d;
      clr_y_q       <= clr_y_d;
      end_pending_q <= end_pending_d;
      frame_busy_q  <= (state_d != ST_IDLE);
      frame_done_q  <= (state_q == ST_DISPATCH) && (state_d == ST_IDLE);
      rast_start_q  <= (state_d == ST_LAUNCH);
      if (pop) rast_tri_q <= head;
    end
  end

  assign bus.frame_busy    = frame_busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.rast_start    = rast_start_q;
  assign bus.rast_p1       = rast_tri_q.p1;
  assign bus.rast_p2       = rast_tri_q.p2;
  assign bus.rast_p3       = rast_tri_q.p3;
  assign bus.rast_color    = rast_tri_q.color;
  assign bus.rast_zb_rdata = bus.zb_rdata;

  // Memory port mux: clear engine owns the ports during CLEAR, else rasterizer pass-through.
  always_comb begin
    bus.fb_we    = 1'b0;
    bus.fb_x     = '0;
    bus.fb_y     = '0;
    bus.fb_data  = '0;
    bus.zb_we    = 1'b0;
    bus.zb_x     = '0;
    bus.zb_y     = '0;
    bus.zb_wdata = '0;
    if (state_q == ST_CLEAR) begin
      bus.fb_we    = 1'b1;
      bus.fb_x     = clr_x_q;
      bus.fb_y     = clr_y_q;
      bus.fb_data  = BG_VAL;
      bus.zb_we    = 1'b1;
      bus.zb_x     = clr_x_q;
      bus.zb_y     = clr_y_q;
      bus.zb_wdata = Z_FAR_VAL;
    end else begin
      if (bus.rast_fb_we) begin
        bus.fb_we   = 1'b1;
        bus.fb_x    = bus.rast_fb_x;
        bus.fb_y    = bus.rast_fb_y;
        bus.fb_data = bus.rast_fb_data;
      end
      if (bus.rast_zb_we) begin
        bus.zb_we    = 1'b1;
        bus.zb_x     = bus.rast_zb_x;
        bus.zb_y     = bus.rast_zb_y;
        bus.zb_wdata = bus.rast_zb_wdata;
      end
    end
  end

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Bench for triangle_dispatcher: pass-through table, clear/dispatch/backpressure/reset sequences, random frames.
module tb_triangle_dispatcher;
  import triangle_dispatcher_pkg::*;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  triangle_dispatcher_if bus();

  triangle_dispatcher #(.FIFO_DEPTH(D), .H_RES(H), .V_RES(V)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Rasterizer model: done drops the cycle after start, rises rm_lat cycles later.
  logic rm_done = 1'b1;
  int   rm_cnt  = 0;
  int   rm_lat  = 4;
  assign bus.rast_done = rm_done;
  always @(posedge clk) begin
    if (areset) begin
      rm_done <= 1'b1;
      rm_cnt  <= 0;
    end else if (bus.rast_start) begin
      rm_done <= 1'b0;
      rm_cnt  <= rm_lat - 1;
    end else if (!rm_done) begin
      if (rm_cnt == 0) rm_done <= 1'b1;
      else             rm_cnt  <= rm_cnt - 1;
    end
  end

  // Reference model: accepted triangles must launch in arrival order, each held while rasterizing.
  triangle_t exp_q[$];
  triangle_t held;
  int n_starts = 0;
  int n_done   = 0;
  int n_acc    = 0;

  function automatic triangle_t rast_tri();
    return '{p1: bus.rast_p1, p2: bus.rast_p2, p3: bus.rast_p3, color: bus.rast_color};
  endfunction

  function automatic triangle_t in_tri();
    return '{p1: bus.tri_p1, p2: bus.tri_p2, p3: bus.tri_p3, color: bus.tri_color};
  endfunction

  always @(negedge clk) begin
    if (!areset) begin
      if (bus.tri_valid && bus.tri_ready) begin
        exp_q.push_back(in_tri());
        n_acc++;
      end
      if (bus.rast_start) begin
        n_starts++;
        check("start_while_rast_busy", 320'(rm_done), 320'(1'b1));
        check("launch_has_pending_tri", 320'(exp_q.size() != 0), 320'(1'b1));
        if (exp_q.size() != 0) check("launch_tri", 320'(rast_tri()), 320'(exp_q.pop_front()));
        held = rast_tri();
      end else if (!rm_done) begin
        check("vertices_held", 320'(rast_tri()), 320'(held));
      end
      if (bus.frame_done) n_done++;
    end
  end

  function automatic triangle_t rand_tri();
    triangle_t t;
    t.p1    = {$urandom, $urandom, $urandom};
    t.p2    = {$urandom, $urandom, $urandom};
    t.p3    = {$urandom, $urandom, $urandom};
    t.color = 4'($urandom);
    return t;
  endfunction

  function automatic logic [51:0] mem_out();
    return {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_data, bus.zb_we, bus.zb_x, bus.zb_y, bus.zb_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tri(input triangle_t t, input logic v);
    bus.tri_valid = v;
    bus.tri_p1    = t.p1;
    bus.tri_p2    = t.p2;
    bus.tri_p3    = t.p3;
    bus.tri_color = t.color;
  endtask

  task automatic set_rast_req(input logic [24:0] fb, input logic [26:0] zb);
    {bus.rast_fb_we, bus.rast_fb_x, bus.rast_fb_y, bus.rast_fb_data} = fb;
    {bus.rast_zb_we, bus.rast_zb_x, bus.rast_zb_y, bus.rast_zb_wdata} = zb;
  endtask

  task automatic pulse_frame(input logic st, input logic en);
    bus.frame_start = st;
    bus.frame_end   = en;
    tick();
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
  endtask

  // Returns at the negedge of the cycle where rast_start is seen.
  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.rast_start) found = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_frame_done(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.frame_done) found = 1'b1;
      else tick();
    end
  endtask

  typedef struct {
    logic [24:0] in_fb;
    logic [26:0] in_zb;
    logic [5:0]  in_rdata;
    logic [51:0] exp_mem;
    logic [5:0]  exp_rdata;
  } pt_vec_t;

  pt_vec_t   vecs[4];
  triangle_t tv[5];
  bit        found;
  int        s0, d0, a0, cyc, d_cnt, d_cyc, s_cnt;

  initial begin
    vecs[0] = '{in_fb: {1'b1, 10'd5, 10'd7, 4'hF}, in_zb: {1'b0, 10'd3, 10'd2, 6'h2A}, in_rdata: 6'h15,
                exp_mem: {1'b1, 10'd5, 10'd7, 4'hF, 1'b0, 10'd0, 10'd0, 6'h00}, exp_rdata: 6'h15};
    vecs[1] = '{in_fb: {1'b0, 10'd9, 10'd9, 4'hA}, in_zb: {1'b1, 10'd1023, 10'd512, 6'h3F}, in_rdata: 6'h00,
                exp_mem: {1'b0, 10'd0, 10'd0, 4'h0, 1'b1, 10'd1023, 10'd512, 6'h3F}, exp_rdata: 6'h00};
    vecs[2] = '{in_fb: {1'b1, 10'd0, 10'd0, 4'h0}, in_zb: {1'b1, 10'd100, 10'd200, 6'h01}, in_rdata: 6'h3F,
                exp_mem: {1'b1, 10'd0, 10'd0, 4'h0, 1'b1, 10'd100, 10'd200, 6'h01}, exp_rdata: 6'h3F};
    vecs[3] = '{in_fb: {1'b0, 10'd1023, 10'd1023, 4'hF}, in_zb: {1'b0, 10'd1023, 10'd1023, 6'h3F}, in_rdata: 6'h2A,
                exp_mem: 52'd0, exp_rdata: 6'h2A};

    areset = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.zb_rdata    = '0;
    drive_tri('0, 1'b0);
    set_rast_req('0, '0);
    tick();
    tick();
    areset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tri_ready", 320'(bus.tri_ready), 320'(1'b1));
    check("rst_status", 320'({bus.frame_busy, bus.frame_done, bus.rast_start}), 320'(3'b000));
    check("rst_rast_tri", 320'(rast_tri()), 320'(0));
    check("rst_mem_ports", 320'(mem_out()), 320'(0));

    // Pass-through table, applied in IDLE
    for (int i = 0; i < 4; i++) begin
      tick();
      set_rast_req(vecs[i].in_fb, vecs[i].in_zb);
      bus.zb_rdata = vecs[i].in_rdata;
      @(negedge clk);
      check($sformatf("passthru_mem[%0d]", i), 320'(mem_out()), 320'(vecs[i].exp_mem));
      check($sformatf("passthru_rdata[%0d]", i), 320'(bus.rast_zb_rdata), 320'(vecs[i].exp_rdata));
    end
    tick();
    set_rast_req('0, '0);

    // Clear sweep then dispatch of two queued triangles
    rm_lat = 4;
    s0 = n_starts;
    d0 = n_done;
    drive_tri(rand_tri(), 1'b1);
    tick();
    drive_tri(rand_tri(), 1'b1);
    tick();
    bus.tri_valid = 1'b0;
    pulse_frame(1'b1, 1'b0);
    for (int i = 0; i < int'(H * V); i++) begin
      @(negedge clk);
      check($sformatf("clear_px%0d", i), 320'(mem_out()),
            320'({1'b1, 10'(i % H), 10'(i / H), 4'h0, 1'b1, 10'(i % H), 10'(i / H), 6'h3F}));
      if (i == 0) check("clear_busy", 320'(bus.frame_busy), 320'(1'b1));
      tick();
    end
    @(negedge clk);
    check("clear_ended", 320'({bus.fb_we, bus.zb_we}), 320'(2'b00));
    pulse_frame(1'b0, 1'b1);
    wait_start(40, found);
    check("first_start_seen", 320'(found), 320'(1'b1));
    tick();
    tick();
    set_rast_req({1'b1, 10'd5, 10'd7, 4'hF}, '0);
    @(negedge clk);
    check("passthru_wait_done", 320'(mem_out()), 320'({1'b1, 10'd5, 10'd7, 4'hF, 27'd0}));
    tick();
    set_rast_req('0, '0);
    wait_frame_done(100, found);
    check("dispatch_frame_done", 320'(found), 320'(1'b1));
    tick();
    tick();
    tick();
    @(negedge clk);
    check("dispatch_starts", 320'(n_starts - s0), 320'(2));
    check("dispatch_done_once", 320'(n_done - d0), 320'(1));
    check("dispatch_busy_low", 320'(bus.frame_busy), 320'(1'b0));

    // Backpressure during CLEAR plus dropped rasterizer request
    rm_lat = 2;
    s0 = n_starts;
    for (int i = 0; i < 5; i++) tv[i] = rand_tri();
    tick();
    pulse_frame(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_tri(tv[k], 1'b1);
      @(negedge clk);
      check($sformatf("bp_ready%0d", k), 320'(bus.tri_ready), 320'(1'b1));
      tick();
    end
    drive_tri(tv[4], 1'b1);
    @(negedge clk);
    check("bp_full", 320'(bus.tri_ready), 320'(1'b0));
    tick();
    set_rast_req({1'b1, 10'd5, 10'd7, 4'hF}, {1'b1, 10'd3, 10'd3, 6'h01});
    @(negedge clk);
    check("clear_drops_rast", 320'(mem_out()),
          320'({1'b1, 10'd1, 10'd1, 4'h0, 1'b1, 10'd1, 10'd1, 6'h3F}));
    tick();
    set_rast_req('0, '0);
    cyc = 7;
    found = 1'b0;
    while (cyc < 30 && !found) begin
      @(negedge clk);
      if (bus.tri_ready) found = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    check("bp_accept_cycle", 320'(cyc), 320'(10));
    tick();
    bus.tri_valid = 1'b0;
    pulse_frame(1'b0, 1'b1);
    wait_frame_done(200, found);
    check("bp_frame_done", 320'(found), 320'(1'b1));
    check("bp_starts", 320'(n_starts - s0), 320'(5));
    check("bp_queue_drained", 320'(exp_q.size()), 320'(0));

    // Empty frame: frame_end during CLEAR
    tick();
    s0 = n_starts;
    d_cnt = 0;
    d_cyc = 0;
    s_cnt = 0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      bus.frame_end = (c == 3);
      @(negedge clk);
      if (c == 1) check("empty_busy", 320'(bus.frame_busy), 320'(1'b1));
      if (bus.frame_done) begin
        d_cnt++;
        d_cyc = c;
      end
      if (bus.rast_start) s_cnt++;
      tick();
    end
    bus.frame_end = 1'b0;
    check("empty_done_once", 320'(d_cnt), 320'(1));
    check("empty_done_after_clear", 320'(d_cyc >= 9 && d_cyc <= 11), 320'(1'b1));
    check("empty_no_start", 320'(s_cnt), 320'(0));
    @(negedge clk);
    check("empty_busy_low", 320'(bus.frame_busy), 320'(1'b0));

    // Reset in the middle of a rasterization with two triangles still queued
    tick();
    rm_lat = 6;
    for (int i = 0; i < 3; i++) begin
      drive_tri(rand_tri(), 1'b1);
      tick();
    end
    bus.tri_valid = 1'b0;
    pulse_frame(1'b1, 1'b0);
    wait_start(40, found);
    check("rst_seq_start_seen", 320'(found), 320'(1'b1));
    tick();
    tick();
    @(negedge clk);
    check("rst_seq_in_wait_done", 320'(rm_done), 320'(1'b0));
    tick();
    areset = 1'b1;
    exp_q.delete();
    tick();
    areset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 320'(bus.tri_ready), 320'(1'b1));
    check("midrst_busy", 320'(bus.frame_busy), 320'(1'b0));
    check("midrst_rast_tri", 320'(rast_tri()), 320'(0));
    d_cnt = 0;
    s_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      @(negedge clk);
      if (bus.frame_done) d_cnt++;
      if (bus.rast_start) s_cnt++;
    end
    check("midrst_no_done", 320'(d_cnt), 320'(0));
    check("midrst_no_start", 320'(s_cnt), 320'(0));
    s0 = n_starts;
    tick();
    pulse_frame(1'b1, 1'b1);
    pulse_frame(1'b0, 1'b1);
    wait_frame_done(40, found);
    check("midrst_flushed_frame_done", 320'(found), 320'(1'b1));
    check("midrst_flushed_no_start", 320'(n_starts - s0), 320'(0));

    // Random frames against the in-order launch model
    for (int f = 0; f < 6; f++) begin
      tick();
      rm_lat = int'($urandom_range(1, 5));
      s0 = n_starts;
      d0 = n_done;
      a0 = n_acc;
      pulse_frame(1'b1, 1'b0);
      for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
        drive_tri(rand_tri(), 1'($urandom));
        bus.frame_start = ($urandom_range(0, 9) == 0);
        tick();
      end
      bus.tri_valid   = 1'b0;
      bus.frame_start = 1'b0;
      pulse_frame(1'b0, 1'b1);
      wait_frame_done(3000, found);
      check($sformatf("rand%0d_frame_done", f), 320'(found), 320'(1'b1));
      tick();
      tick();
      @(negedge clk);
      check($sformatf("rand%0d_all_launched", f), 320'(n_starts - s0), 320'(n_acc - a0));
      check($sformatf("rand%0d_queue_empty", f), 320'(exp_q.size()), 320'(0));
      check($sformatf("rand%0d_done_once", f), 320'(n_done - d0), 320'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
